// File: rtl/des_pkg.sv
// des_pkg: DES tables, state encoding and permutation helpers shared by the core, round step and f_function
package des_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int STEP_W = $clog2(16) + 1;
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
        10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
        14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
        23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int E_T [48] = '{
        32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9,
        8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
    localparam int P_T [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    localparam int SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    // Last entry is never applied to a subkey; 1 closes the 28-bit rotation cycle.
    localparam int RSHIFT [16] = '{1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1, 1};
    // Entry [s][row*16+col], row = {b1,b6}, col = b2..b5 of the 6-bit S-box input.
    localparam int SBOX [8][64] = '{
        '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
          0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
          4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
          15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
        '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
          3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
          0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
          13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
        '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
          13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
          1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
        '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
          13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
          10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
          3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
        '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
          14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
          4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
          11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
        '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
          10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
          9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
          4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
        '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
          13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
          1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
          6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
        '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
          1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
          7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
          2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};
    // Tables use DES numbering: entry value n names input bit n counted from the MSB.
    function automatic logic [63:0] permute64(input logic [63:0] x, input int t [64]);
        logic [63:0] y = '0;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - t[i])];
        return y;
    endfunction
    function automatic logic [63:0] ip(input logic [63:0] x);
        return permute64(x, IP_T);
    endfunction
    function automatic logic [63:0] fp(input logic [63:0] x);
        return permute64(x, FP_T);
    endfunction
    function automatic logic [55:0] pc1(input logic [63:0] x);
        logic [55:0] y = '0;
        for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[i])];
        return y;
    endfunction
    function automatic logic [47:0] pc2(input logic [55:0] x);
        logic [47:0] y = '0;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[i])];
        return y;
    endfunction
    function automatic logic [47:0] e_exp(input logic [31:0] x);
        logic [47:0] y = '0;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_T[i])];
        return y;
    endfunction
    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y = '0;
        for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_T[i])];
        return y;
    endfunction
endpackage

// File: rtl/des_round_step.sv
// des_round_step: one Feistel round with its key-schedule rotation and PC2
//   l, r           : current halves          l_next, r_next : halves after the round
//   c, d           : current key halves      c_next, d_next : key halves after rotation
//   mode           : 0 encrypt, 1 decrypt    round          : round index 0..15
module des_round_step
    import des_pkg::*;
(
    input  logic [31:0] l,
    input  logic [31:0] r,
    input  logic [27:0] c,
    input  logic [27:0] d,
    input  logic        mode,
    input  logic [3:0]  round,
    output logic [31:0] l_next,
    output logic [31:0] r_next,
    output logic [27:0] c_next,
    output logic [27:0] d_next
);
    logic        two;
    logic [27:0] c_l, d_l, c_r, d_r;
    logic [47:0] k;
    logic [31:0] f;
    // Encrypt rotates left before PC2; decrypt uses PC2 first then rotates right,
    // which walks the subkeys K16..K1 without storing them.
    always_comb begin
        two = (mode ? RSHIFT[round] : SHIFT[round]) == 2;
        c_l = two ? {c[25:0], c[27:26]} : {c[26:0], c[27]};
        d_l = two ? {d[25:0], d[27:26]} : {d[26:0], d[27]};
        c_r = two ? {c[1:0], c[27:2]} : {c[0], c[27:1]};
        d_r = two ? {d[1:0], d[27:2]} : {d[0], d[27:1]};
        c_next = mode ? c_r : c_l;
        d_next = mode ? d_r : d_l;
        k = mode ? pc2({c, d}) : pc2({c_l, d_l});
        l_next = r;
        r_next = l ^ f;
    end
    f_function u_f (.r(r), .k(k), .f(f));
endmodule

// File: rtl/f_function.sv
// f_function: combinational DES round function f(R,K) = P(S(E(R) ^ K))
//   r : 32-bit right half, k : 48-bit subkey, f : 32-bit result
module f_function
    import des_pkg::*;
(
    input  logic [31:0] r,
    input  logic [47:0] k,
    output logic [31:0] f
);
    logic [47:0] x;
    logic [31:0] s;
    assign x = e_exp(r) ^ k;
    for (genvar g = 0; g < 8; g++) begin : g_sbox
        assign s[31-4*g -: 4] = 4'(SBOX[g][{x[47-6*g], x[42-6*g], x[46-6*g -: 4]}]);
    end
    assign f = p_perm(s);
endmodule

// File: rtl/des_iter_core.sv
// des_iter_core: iterative DES encrypt/decrypt engine, ROUNDS_PER_CYCLE rounds per clock
//   clk, rst                     : clock, synchronous active-high reset
//   in_valid/in_ready            : request handshake (in_ready only in IDLE)
//   in_decrypt, in_key, in_data  : mode, 64-bit key, 64-bit block (sampled at accept)
//   out_valid/out_ready/out_data : result handshake, data held until accepted
module des_iter_core #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_decrypt,
    input  logic [63:0] in_key,
    input  logic [63:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data
);
    import des_pkg::*;
    localparam int NUM_STEPS = 16 / ROUNDS_PER_CYCLE;
    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4 &&
        ROUNDS_PER_CYCLE != 8 && ROUNDS_PER_CYCLE != 16) begin : g_bad_rpc
        $error("des_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end
    state_t             state, state_n;
    logic [31:0]        l, r;
    logic [27:0]        c, d;
    logic               mode;
    logic [STEP_W-1:0]  step;
    logic               last;
    logic [31:0]        lc [ROUNDS_PER_CYCLE+1];
    logic [31:0]        rc [ROUNDS_PER_CYCLE+1];
    logic [27:0]        cc [ROUNDS_PER_CYCLE+1];
    logic [27:0]        dc [ROUNDS_PER_CYCLE+1];
    assign lc[0] = l;
    assign rc[0] = r;
    assign cc[0] = c;
    assign dc[0] = d;
    for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_round
        des_round_step u_step (
            .l(lc[j]), .r(rc[j]), .c(cc[j]), .d(dc[j]), .mode(mode),
            .round(4'(int'(step) * ROUNDS_PER_CYCLE + j)),
            .l_next(lc[j+1]), .r_next(rc[j+1]), .c_next(cc[j+1]), .d_next(dc[j+1])
        );
    end
    assign last = step == STEP_W'(NUM_STEPS - 1);
    always_ff @(posedge clk) state <= rst ? IDLE : state_n;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = in_valid ? RUN : IDLE;
            RUN:     state_n = last ? DONE : RUN;
            DONE:    state_n = out_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end
    always_comb begin
        in_ready = state == IDLE;
        out_valid = state == DONE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            l <= '0;
            r <= '0;
            c <= '0;
            d <= '0;
            mode <= 1'b0;
            step <= '0;
            out_data <= '0;
        end else if (state == IDLE && in_valid) begin
            {l, r} <= ip(in_data);
            {c, d} <= pc1(in_key);
            mode <= in_decrypt;
            step <= '0;
        end else if (state == RUN) begin
            l <= lc[ROUNDS_PER_CYCLE];
            r <= rc[ROUNDS_PER_CYCLE];
            c <= cc[ROUNDS_PER_CYCLE];
            d <= dc[ROUNDS_PER_CYCLE];
            step <= step + 1'b1;
            // Final halves are swapped before the inverse permutation.
            if (last) out_data <= fp({rc[ROUNDS_PER_CYCLE], lc[ROUNDS_PER_CYCLE]});
        end
    end
endmodule

// File: doc/des_iter_core.md
Name: des_iter_core

Overview:
Iterative DES encrypt/decrypt engine built around the existing combinational f_function.
- Accepts a 64-bit block, a 64-bit key and a mode bit through a valid/ready handshake.
- Runs the 16 Feistel rounds with an on-the-fly key schedule, ROUNDS_PER_CYCLE rounds per clock.
- Returns the 64-bit result through a valid/ready handshake.
- Sits between the block-mode wrapper (ECB/CBC sequencing) and the round logic. It is the first clocked DES datapath in the design.

Parameters:
ROUNDS_PER_CYCLE, 1, Feistel rounds evaluated per clock. Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration-time error.
NUM_STEPS, 16/ROUNDS_PER_CYCLE, derived localparam (not overridable): number of RUN cycles.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  request present
in_ready  output  1  core can accept; high only in IDLE
in_decrypt  input  1  0 = encrypt, 1 = decrypt
in_key  input  64  DES key; parity bits (LSB of each byte) ignored
in_data  input  64  plaintext or ciphertext block, bit 63 = DES bit 1
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
out_data  output  64  result block

Behaviour:
- Reset: synchronous and active-high, sampled on the rising edge of clk.
  - State goes to IDLE.
  - out_valid=0, out_data=0, in_ready=1, and all internal L/R/C/D/counter registers are 0.
  - Reset mid-RUN or mid-DONE abandons the operation; nothing is output.
- State machine: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge, the core registers:
    - L,R = IP(in_data);
    - C,D = PC1(in_key);
    - mode = in_decrypt;
    - step = 0.
  - Next state is RUN.
- RUN:
  - in_ready=0. Each cycle applies ROUNDS_PER_CYCLE chained rounds: L'=R, R'=L^f(R,K).
  - Key schedule, encrypt: before each round's PC2, rotate C and D left by SHIFT[i], where SHIFT = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Key schedule, decrypt: take PC2 first, then rotate right by RSHIFT[i], where RSHIFT = 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1,(unused). This yields subkeys K16..K1.
  - step increments once per cycle. On the cycle with step==NUM_STEPS-1, out_data = FP({R16,L16}) (swap applied), out_valid=1, and next state is DONE.
- DONE:
  - out_valid=1; out_data is held stable until out_valid&&out_ready.
  - On that handshake: out_valid=0 and next state is IDLE.
  - in_valid is ignored while in DONE.
- Latency: if the accept edge is edge 0, out_valid rises after edge NUM_STEPS.
  - RPC=1 gives 16 cycles; RPC=16 gives 1 cycle.
  - Minimum initiation interval is NUM_STEPS+2 cycles (accept, run, drain).
- in_ready is combinational from state only. It has no path from out_ready.
- If out_ready is already high when out_valid rises, the handshake completes on the next edge.
- No arithmetic beyond XOR and permutations. C and D rotate modulo 28 bits. step counter width is clog2(16)+1.
- in_key, in_data and in_decrypt are sampled only at the accept edge. Changes afterwards have no effect.

Decomposition:
- Package des_pkg holds:
  - permutation tables IP, FP, PC1 and PC2 as constant index arrays;
  - SHIFT and RSHIFT schedules;
  - state enum and function helpers permute64, pc1, pc2 and fp.
  - The existing S-box and E/P tables move into this package so f_function shares them.
- One sub-module: des_round_step.
  - It wraps one f_function instance plus one key-schedule rotation and PC2.
  - It takes L, R, C, D, mode and a round index, and returns L', R', C', D'.
  - The core instantiates ROUNDS_PER_CYCLE copies in a generate chain.

Test Plan:
1. RPC=1, encrypt, key 133457799BBCDFF1, data 0123456789ABCDEF -> out_data 85E813540F0AB405. out_valid rises exactly 16 cycles after accept; in_ready is 0 throughout.
2. RPC=1, decrypt, key 133457799BBCDFF1, data 85E813540F0AB405 -> out_data 0123456789ABCDEF.
3. RPC=4, encrypt, key 0E329232EA6D0D73, data 8787878787878787 -> out_data 0000000000000000 after 4 cycles. Decrypt of 0000000000000000 returns 8787878787878787.
4. Backpressure: after test 1 completes, hold out_ready=0 for 5 cycles and pulse in_valid with data FFFFFFFFFFFFFFFF.
   - out_data stays 85E813540F0AB405 and in_ready stays 0; the pulse is not accepted.
   - After out_ready=1, there is one handshake, then in_ready=1.
5. Reset mid-run: assert rst for 1 cycle at RUN step 7 of test 1.
   - The next cycle shows out_valid=0, out_data=0, in_ready=1.
   - Re-issuing test 1 yields 85E813540F0AB405 with full latency.
6. RPC=16, out_ready tied high, three back-to-back requests (vectors 1, 2, 3): each result appears 1 cycle after its accept, in order, with the initiation interval of 3 cycles.
